// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//   Shares one external combinational ALU between two requesters. At most one
//   requester is granted per cycle. The granted requester's operands and opcode
//   are muxed onto the ALU drive ports. The ALU result is captured into that
//   requester's response register on the grant edge, so the latency is one
//   cycle. A requester can only be granted when its response slot is free.
//   The slot is free when no response is pending, or when the pending response
//   is being consumed in the same cycle.
//
// Arbitration:
//   Default build: round-robin on ties. The requester not named by last_grant
//   wins a tie. last_grant resets to 1, so requester 0 wins the first tie.
//   With ALU_ARB_FIXED_PRIO_EN defined, requester 0 always wins a tie and no
//   last_grant state exists.
//
// Ports:
//   clk                      clock, rising edge
//   reset                    asynchronous, active-low reset
//   req_valid0/1             requester i presents an operation
//   req_ready0/1             requester i granted this cycle (combinational)
//   inA0/1, inB0/1           requester operands (DATA_W)
//   ALUctrl0/1               requester opcode (3 bits, passed through as-is)
//   saveHigh0/1              requester saveHigh qualifier
//   alu_inA/alu_inB          shared ALU operands (DATA_W)
//   alu_ALUctrl              shared ALU opcode
//   alu_saveHigh             shared ALU saveHigh qualifier
//   alu_result/alu_zero      combinational ALU outputs
//   rsp_valid0/1             registered response pending for requester i
//   rsp_ready0/1             requester i consumes its response
//   result0/1, zero0/1       registered response data
//   ops_done                 completed-grant counter (CNT_W, wraps)
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req_valid0,
    input  logic              req_valid1,
    output logic              req_ready0,
    output logic              req_ready1,
    input  logic [DATA_W-1:0] inA0,
    input  logic [DATA_W-1:0] inA1,
    input  logic [DATA_W-1:0] inB0,
    input  logic [DATA_W-1:0] inB1,
    input  logic [2:0]        ALUctrl0,
    input  logic [2:0]        ALUctrl1,
    input  logic              saveHigh0,
    input  logic              saveHigh1,

    output logic [DATA_W-1:0] alu_inA,
    output logic [DATA_W-1:0] alu_inB,
    output logic [2:0]        alu_ALUctrl,
    output logic              alu_saveHigh,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,

    output logic              rsp_valid0,
    output logic              rsp_valid1,
    input  logic              rsp_ready0,
    input  logic              rsp_ready1,
    output logic [DATA_W-1:0] result0,
    output logic [DATA_W-1:0] result1,
    output logic              zero0,
    output logic              zero1,

    output logic [CNT_W-1:0]  ops_done
);

    // Per-requester views of the scalar ports, so that the response logic can
    // be generated once per requester.
    logic [1:0]        req_valid;
    logic [1:0]        rsp_ready;
    logic [1:0]        rsp_valid;
    logic [1:0]        zero_q;
    logic [DATA_W-1:0] result_q [2];
    logic [1:0]        elig;
    logic [1:0]        grant;

    assign req_valid = {req_valid1, req_valid0};
    assign rsp_ready = {rsp_ready1, rsp_ready0};

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Round-robin pointer: it names the requester that was granted last.
    typedef enum logic {
        LAST_REQ0 = 1'b0,
        LAST_REQ1 = 1'b1
    } last_t;

    last_t last_grant_reg;
    last_t last_grant_next;
`endif

    logic [CNT_W-1:0] ops_done_reg;

    // ------------------------------------------------------------------
    // Eligibility. A pending response that is consumed this cycle frees
    // the slot, so a new grant can be issued in the same cycle.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_elig
            assign elig[gi] = req_valid[gi] & (~rsp_valid[gi] | rsp_ready[gi]);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Grant selection (combinational). No grant is issued while reset is
    // held low. This keeps req_ready low during reset, even though the
    // state registers are already cleared.
    // ------------------------------------------------------------------
    always_comb begin
        grant = 2'b00;
        if (reset) begin
            case (elig)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
`ifdef ALU_ARB_FIXED_PRIO_EN
                2'b11:   grant = 2'b01;
`else
                2'b11:   grant = (last_grant_reg == LAST_REQ1) ? 2'b01 : 2'b10;
`endif
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready0 = grant[0];
    assign req_ready1 = grant[1];

    // ------------------------------------------------------------------
    // Shared ALU drive mux. The ports are zero when there is no grant.
    // The opcode is never decoded, so unsupported codes pass through.
    // ------------------------------------------------------------------
    always_comb begin
        alu_inA      = '0;
        alu_inB      = '0;
        alu_ALUctrl  = 3'b000;
        alu_saveHigh = 1'b0;
        if (grant[0]) begin
            alu_inA      = inA0;
            alu_inB      = inB0;
            alu_ALUctrl  = ALUctrl0;
            alu_saveHigh = saveHigh0;
        end else if (grant[1]) begin
            alu_inA      = inA1;
            alu_inB      = inB1;
            alu_ALUctrl  = ALUctrl1;
            alu_saveHigh = saveHigh1;
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    // ------------------------------------------------------------------
    // Round-robin pointer: next-state logic and state register.
    // ------------------------------------------------------------------
    always_comb begin
        last_grant_next = last_grant_reg;
        if (grant[0]) begin
            last_grant_next = LAST_REQ0;
        end else if (grant[1]) begin
            last_grant_next = LAST_REQ1;
        end
    end

    // Reset to requester 1, so that requester 0 wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_reg <= LAST_REQ1;
        end else begin
            last_grant_reg <= last_grant_next;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Response registers, one set per requester.
    // A grant takes precedence over a consume. When both happen in the
    // same cycle, the slot stays valid and is loaded with the new result.
    // A consume with nothing pending leaves the slot clear.
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_rsp
            logic              rsp_valid_reg;
            logic [DATA_W-1:0] result_reg;
            logic              zero_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rsp_valid_reg <= 1'b0;
                    result_reg    <= '0;
                    zero_reg      <= 1'b0;
                end else if (grant[gi]) begin
                    rsp_valid_reg <= 1'b1;
                    result_reg    <= alu_result;
                    zero_reg      <= alu_zero;
                end else if (rsp_ready[gi]) begin
                    rsp_valid_reg <= 1'b0;
                end
            end

            assign rsp_valid[gi] = rsp_valid_reg;
            assign result_q[gi]  = result_reg;
            assign zero_q[gi]    = zero_reg;
        end
    endgenerate

    assign rsp_valid0 = rsp_valid[0];
    assign rsp_valid1 = rsp_valid[1];
    assign result0    = result_q[0];
    assign result1    = result_q[1];
    assign zero0      = zero_q[0];
    assign zero1      = zero_q[1];

    // ------------------------------------------------------------------
    // Completed-grant counter. It wraps naturally at 2^CNT_W.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ops_done_reg <= '0;
        end else if (|grant) begin
            ops_done_reg <= ops_done_reg + 1'b1;
        end
    end

    assign ops_done = ops_done_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Self-checking bench for alu_arbiter. A behavioural ALU sits on the shared
// ALU ports. A reference model tracks the pending responses, the tie-break
// pointer and the grant count, using plain arrays and arithmetic.
// ops_done is instantiated narrow (4 bits) so that the random run wraps it.
// Inputs change on the falling edge and combinational outputs are sampled
// shortly after. Registered outputs are sampled 1 time unit after the rising
// edge.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid0, req_valid1;
    logic          req_ready0, req_ready1;
    logic [DW-1:0] inA0, inA1, inB0, inB1;
    logic [2:0]    ALUctrl0, ALUctrl1;
    logic          saveHigh0, saveHigh1;
    logic [DW-1:0] alu_inA, alu_inB;
    logic [2:0]    alu_ALUctrl;
    logic          alu_saveHigh;
    logic [DW-1:0] alu_result;
    logic          alu_zero;
    logic          rsp_valid0, rsp_valid1;
    logic          rsp_ready0, rsp_ready1;
    logic [DW-1:0] result0, result1;
    logic          zero0, zero1;
    logic [CW-1:0] ops_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .req_valid0(req_valid0), .req_valid1(req_valid1),
        .req_ready0(req_ready0), .req_ready1(req_ready1),
        .inA0(inA0), .inA1(inA1), .inB0(inB0), .inB1(inB1),
        .ALUctrl0(ALUctrl0), .ALUctrl1(ALUctrl1),
        .saveHigh0(saveHigh0), .saveHigh1(saveHigh1),
        .alu_inA(alu_inA), .alu_inB(alu_inB),
        .alu_ALUctrl(alu_ALUctrl), .alu_saveHigh(alu_saveHigh),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
        .rsp_ready0(rsp_ready0), .rsp_ready1(rsp_ready1),
        .result0(result0), .result1(result1),
        .zero0(zero0), .zero1(zero1),
        .ops_done(ops_done)
    );

    // Behavioural ALU environment: ADD, SUB, OR, and AND for unlisted codes.
    function automatic logic [DW-1:0] alu_fn(input logic [2:0] op,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a | b;
            default: return a & b;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_ALUctrl, alu_inA, alu_inB);
    assign alu_zero   = (alu_result == '0);

    // ---------------- reference model ----------------
    bit            m_pend [2];
    logic [DW-1:0] m_res  [2];
    bit            m_zero [2];
    int            m_last;
    int            m_cnt;
    bit            e_g0, e_g1;
    logic [DW-1:0] e_a, e_b;
    logic [2:0]    e_c;
    logic          e_s;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = 0;
            m_res[i]  = '0;
            m_zero[i] = 0;
        end
        m_last = 1;
        m_cnt  = 0;
    endtask

    // Expected grant and ALU drive values for the current inputs.
    task automatic predict();
        bit el0, el1;
        el0  = reset && req_valid0 && (!m_pend[0] || rsp_ready0);
        el1  = reset && req_valid1 && (!m_pend[1] || rsp_ready1);
        e_g0 = 0;
        e_g1 = 0;
        if (el0 && el1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            e_g0 = 1;
`else
            if (m_last == 1) e_g0 = 1;
            else             e_g1 = 1;
`endif
        end else begin
            e_g0 = el0;
            e_g1 = el1;
        end
        e_a = '0; e_b = '0; e_c = 3'd0; e_s = 1'b0;
        if (e_g0) begin
            e_a = inA0; e_b = inB0; e_c = ALUctrl0; e_s = saveHigh0;
        end else if (e_g1) begin
            e_a = inA1; e_b = inB1; e_c = ALUctrl1; e_s = saveHigh1;
        end
    endtask

    // Apply one rising edge to the model.
    task automatic commit();
        predict();
        if (e_g0) begin
            m_pend[0] = 1;
            m_res[0]  = alu_fn(ALUctrl0, inA0, inB0);
            m_zero[0] = (m_res[0] == '0);
        end else if (rsp_ready0) begin
            m_pend[0] = 0;
        end
        if (e_g1) begin
            m_pend[1] = 1;
            m_res[1]  = alu_fn(ALUctrl1, inA1, inB1);
            m_zero[1] = (m_res[1] == '0);
        end else if (rsp_ready1) begin
            m_pend[1] = 0;
        end
        if (e_g0 || e_g1) begin
            m_cnt  = (m_cnt + 1) % (1 << CW);
            m_last = e_g0 ? 0 : 1;
        end
    endtask

    task automatic set_idle();
        req_valid0 = 0; req_valid1 = 0;
        rsp_ready0 = 0; rsp_ready1 = 0;
        inA0 = '0; inA1 = '0; inB0 = '0; inB1 = '0;
        ALUctrl0 = 3'd0; ALUctrl1 = 3'd0;
        saveHigh0 = 0; saveHigh1 = 0;
    endtask

    // Consume any pending responses, with no requests presented.
    task automatic drain();
        @(negedge clk);
        set_idle();
        rsp_ready0 = 1; rsp_ready1 = 1;
        @(posedge clk); commit(); #1;
        checks++;
        if (rsp_valid0 !== 1'b0 || rsp_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL drain: rsp_valid={%b,%b} expected {0,0}", rsp_valid1, rsp_valid0);
        end
        @(negedge clk);
        set_idle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        set_idle();
        reset = 0;
        req_valid0 = 1; req_valid1 = 1;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (rsp_valid0 !== 0 || rsp_valid1 !== 0 || result0 !== '0 || result1 !== '0 ||
            zero0 !== 0 || zero1 !== 0 || ops_done !== '0) begin
            errors++;
            $display("FAIL reset_state: rv=%b%b r0=%0h r1=%0h z=%b%b ops=%0d expected all 0",
                     rsp_valid1, rsp_valid0, result0, result1, zero1, zero0, ops_done);
        end
        checks++;
        if (req_ready0 !== 0 || req_ready1 !== 0 || alu_inA !== '0 || alu_ALUctrl !== 3'd0) begin
            errors++;
            $display("FAIL reset_nogrant: ready=%b%b alu_inA=%0h ctrl=%0d expected 0",
                     req_ready1, req_ready0, alu_inA, alu_ALUctrl);
        end
        set_idle();
        reset = 1;
        $display("reset: released");
    endtask

    task automatic test_add();
        @(negedge clk);
        req_valid0 = 1; ALUctrl0 = 3'd0; inA0 = 123; inB0 = 234;
        #1; predict();
        checks++;
        if (req_ready0 !== 1 || req_ready1 !== 0) begin
            errors++;
            $display("FAIL add_grant: ready=%b%b expected 01", req_ready1, req_ready0);
        end
        @(posedge clk); commit(); #1;
        checks++;
        if (rsp_valid0 !== 1 || result0 !== 357 || zero0 !== 0 || ops_done !== 1) begin
            errors++;
            $display("FAIL add_rsp: rv=%b res=%0d z=%b ops=%0d expected 1 357 0 1",
                     rsp_valid0, result0, zero0, ops_done);
        end
        $display("add: result0=%0d ops_done=%0d", result0, ops_done);
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_sub();
        req_valid1 = 1; ALUctrl1 = 3'd1; inA1 = 123; inB1 = 123;
        #1; predict();
        checks++;
        if (req_ready0 !== 0 || req_ready1 !== 1) begin
            errors++;
            $display("FAIL sub_grant: ready=%b%b expected 10", req_ready1, req_ready0);
        end
        @(posedge clk); commit(); #1;
        checks++;
        if (rsp_valid1 !== 1 || result1 !== 0 || zero1 !== 1) begin
            errors++;
            $display("FAIL sub_rsp: rv=%b res=%0d z=%b expected 1 0 1", rsp_valid1, result1, zero1);
        end
        $display("sub: result1=%0d zero1=%b", result1, zero1);
        drain();
    endtask

    task automatic test_round_robin();
        int exp_order [4];
        int got;
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req_valid0 = 1; req_valid1 = 1; rsp_ready0 = 1; rsp_ready1 = 1;
            ALUctrl0 = 3'd0; inA0 = $urandom; inB0 = $urandom;
            ALUctrl1 = 3'd2; inA1 = $urandom; inB1 = $urandom;
            #1; predict();
            got = (req_ready0 === 1 && req_ready1 === 0) ? 0 :
                  (req_ready1 === 1 && req_ready0 === 0) ? 1 : -1;
            checks++;
            if (got != exp_order[k]) begin
                errors++;
                $display("FAIL rr_order[%0d]: granted=%0d expected %0d", k, got, exp_order[k]);
            end
            $display("rr: cycle %0d granted %0d", k, got);
            @(posedge clk); commit();
        end
        drain();
    endtask

    task automatic test_or_savehigh();
        logic [DW-1:0] cap;
        req_valid0 = 1; ALUctrl0 = 3'd2; inA0 = '0; inB0 = 32'hFFFF; saveHigh0 = 1;
        #1; predict();
        cap = alu_result;
        checks++;
        if (req_ready0 !== 1 || alu_saveHigh !== 1 || alu_ALUctrl !== 3'd2 || alu_inB !== 32'hFFFF) begin
            errors++;
            $display("FAIL or_drive: ready0=%b saveHigh=%b ctrl=%0d inB=%0h expected 1 1 2 ffff",
                     req_ready0, alu_saveHigh, alu_ALUctrl, alu_inB);
        end
        @(posedge clk); commit(); #1;
        checks++;
        if (result0 !== 32'hFFFF || result0 !== cap || zero0 !== 0) begin
            errors++;
            $display("FAIL or_rsp: result0=%0h expected ffff (captured %0h)", result0, cap);
        end
        $display("or: result0=%0h", result0);
    endtask

    // Starts with requester 0's response pending from test_or_savehigh.
    task automatic test_backpressure();
        @(negedge clk);
        set_idle();
        req_valid0 = 1; ALUctrl0 = 3'd0; inA0 = 5; inB0 = 6;
        req_valid1 = 1; ALUctrl1 = 3'd1; inA1 = 9; inB1 = 4; rsp_ready1 = 1;
        #1; predict();
        checks++;
        if (req_ready0 !== 0 || req_ready1 !== 1) begin
            errors++;
            $display("FAIL bp_block: ready=%b%b expected 10", req_ready1, req_ready0);
        end
        @(posedge clk); commit(); #1;
        checks++;
        if (rsp_valid0 !== 1 || result0 !== 32'hFFFF || result1 !== 5) begin
            errors++;
            $display("FAIL bp_hold: rv0=%b result0=%0h result1=%0d expected 1 ffff 5",
                     rsp_valid0, result0, result1);
        end
        @(negedge clk);
        req_valid1 = 0; rsp_ready0 = 1;
        #1; predict();
        checks++;
        if (req_ready0 !== 1) begin
            errors++;
            $display("FAIL bp_release: ready0=%b expected 1", req_ready0);
        end
        @(posedge clk); commit(); #1;
        checks++;
        if (rsp_valid0 !== 1 || result0 !== 11) begin
            errors++;
            $display("FAIL bp_replace: rv0=%b result0=%0d expected 1 11", rsp_valid0, result0);
        end
        $display("backpressure: result0=%0d", result0);
        drain();
    endtask

    task automatic test_random();
        int bad = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            req_valid0 = ($urandom_range(0, 3) != 0);
            req_valid1 = ($urandom_range(0, 3) != 0);
            rsp_ready0 = $urandom_range(0, 1);
            rsp_ready1 = $urandom_range(0, 1);
            ALUctrl0 = $urandom_range(0, 7); ALUctrl1 = $urandom_range(0, 7);
            saveHigh0 = $urandom_range(0, 1); saveHigh1 = $urandom_range(0, 1);
            inA0 = $urandom; inA1 = $urandom;
            inB0 = ($urandom_range(0, 3) == 0) ? inA0 : $urandom;
            inB1 = ($urandom_range(0, 3) == 0) ? inA1 : $urandom;
            #1; predict();
            checks++;
            if (req_ready0 !== e_g0 || req_ready1 !== e_g1 || alu_inA !== e_a || alu_inB !== e_b ||
                alu_ALUctrl !== e_c || alu_saveHigh !== e_s) begin
                errors++; bad++;
                $display("FAIL rand_grant[%0d]: ready=%b%b a=%0h b=%0h c=%0d s=%b expected ready=%b%b a=%0h b=%0h c=%0d s=%b",
                         n, req_ready1, req_ready0, alu_inA, alu_inB, alu_ALUctrl, alu_saveHigh,
                         e_g1, e_g0, e_a, e_b, e_c, e_s);
            end
            @(posedge clk); commit(); #1;
            checks++;
            if (rsp_valid0 !== m_pend[0] || rsp_valid1 !== m_pend[1] ||
                (m_pend[0] && (result0 !== m_res[0] || zero0 !== m_zero[0])) ||
                (m_pend[1] && (result1 !== m_res[1] || zero1 !== m_zero[1])) ||
                ops_done !== CW'(m_cnt)) begin
                errors++; bad++;
                $display("FAIL rand_rsp[%0d]: rv=%b%b r0=%0h z0=%b r1=%0h z1=%b ops=%0d expected rv=%b%b r0=%0h z0=%b r1=%0h z1=%b ops=%0d",
                         n, rsp_valid1, rsp_valid0, result0, zero0, result1, zero1, ops_done,
                         m_pend[1], m_pend[0], m_res[0], m_zero[0], m_res[1], m_zero[1], m_cnt);
            end
        end
        $display("random: 400 cycles, %0d bad, ops_done=%0d", bad, ops_done);
        drain();
    endtask

    task automatic test_reset_mid();
        req_valid0 = 1; rsp_ready0 = 1; inA0 = 1; inB0 = 2;
        @(posedge clk); commit();
        @(negedge clk);
        set_idle();
        req_valid1 = 1; rsp_ready1 = 1; inA1 = 3; inB1 = 4;
        @(posedge clk); commit();
        @(negedge clk);
        set_idle();
        checks++;
        if (rsp_valid0 !== 1 || rsp_valid1 !== 1) begin
            errors++;
            $display("FAIL rmid_setup: rv=%b%b expected 11", rsp_valid1, rsp_valid0);
        end
        #2 reset = 0;
        #1;
        model_reset();
        checks++;
        if (rsp_valid0 !== 0 || rsp_valid1 !== 0 || ops_done !== '0) begin
            errors++;
            $display("FAIL rmid_async: rv=%b%b ops=%0d expected 00 0", rsp_valid1, rsp_valid0, ops_done);
        end
        @(negedge clk);
        reset = 1;
        req_valid0 = 1; req_valid1 = 1;
        #1; predict();
        checks++;
        if (req_ready0 !== 1 || req_ready1 !== 0) begin
            errors++;
            $display("FAIL rmid_tie: ready=%b%b expected 01", req_ready1, req_ready0);
        end
        @(posedge clk); commit(); #1;
        checks++;
        if (rsp_valid0 !== 1 || rsp_valid1 !== 0 || ops_done !== 1) begin
            errors++;
            $display("FAIL rmid_first: rv=%b%b ops=%0d expected 01 1", rsp_valid1, rsp_valid0, ops_done);
        end
        $display("reset_mid: first grant after release to requester 0");
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_round_robin();
        test_or_savehigh();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, which sets the operand and result width.
REQ-002 The block SHALL have parameter CNT_W, default 16, which sets the width of the completed-operation counter.
REQ-003 Port clk  input  1  is the single clock; all state updates on the rising edge.
REQ-004 Port reset  input  1  is an asynchronous, active-low reset; the block is in reset while it is 0.
REQ-005 Ports req_valid0/req_valid1  input  1 each  signal that requester 0/1 presents an operation.
REQ-006 Ports req_ready0/req_ready1  output  1 each  signal that the operation is granted and accepted this cycle.
REQ-007 Ports inA0/inA1 and inB0/inB1  input  DATA_W each  carry the requester operands.
REQ-008 Ports ALUctrl0/ALUctrl1  input  3 each  carry the opcode: 000 ADD, 001 SUB, 010 OR.
REQ-009 Ports saveHigh0/saveHigh1  input  1 each  carry the per-requester saveHigh qualifier.
REQ-010 Ports alu_inA and alu_inB  output  DATA_W, alu_ALUctrl  output  3, and alu_saveHigh  output  1  drive the shared ALU.
REQ-011 Ports alu_result  input  DATA_W  and alu_zero  input  1  return the combinational ALU outputs.
REQ-012 Ports rsp_valid0/rsp_valid1  output  1 each  signal that a registered response is pending.
REQ-013 Ports rsp_ready0/rsp_ready1  input  1 each  signal that the requester consumes its response.
REQ-014 Ports result0/result1  output  DATA_W each  and zero0/zero1  output  1 each  carry the registered response.
REQ-015 Port ops_done  output  CNT_W  counts completed grants.

Function
REQ-016 Requester i SHALL be eligible when req_valid_i=1 and its slot is free, i.e. rsp_valid_i=0 or rsp_ready_i=1.
REQ-017 At most one requester SHALL be granted per cycle; req_ready_i is combinational and equals grant_i.
REQ-018 With one eligible requester, it SHALL be granted; with both eligible, the requester not named by last_grant SHALL be granted (round-robin).
REQ-019 last_grant SHALL update to the granted index on every grant and SHALL hold when there is no grant.
REQ-020 The ALU drive ports SHALL mux the granted requester's inA, inB, ALUctrl and saveHigh; with no grant they SHALL drive 0, 000 and 0.
REQ-021 On the grant edge, alu_result/alu_zero SHALL be captured into result_i/zero_i and rsp_valid_i set to 1, giving a latency of 1 cycle.
REQ-022 rsp_valid_i SHALL clear on the edge where rsp_ready_i=1 and no new grant to i occurs; with a simultaneous consume and grant it SHALL stay 1 and the data SHALL be replaced.
REQ-023 result_i/zero_i SHALL hold stable while rsp_valid_i=1 and rsp_ready_i=0.
REQ-024 rsp_ready_i asserted while rsp_valid_i=0 SHALL be ignored.
REQ-025 ops_done SHALL increment by 1 per grant and wrap from 2^CNT_W-1 to 0.
REQ-026 The block SHALL not interpret opcodes; an unsupported ALUctrl SHALL pass through unchanged.

Reset
REQ-027 While reset=0: rsp_valid0/1=0, result0/1=0, zero0/1=0, ops_done=0, last_grant=1 (requester 0 wins the first tie), and no grant is issued.
REQ-028 Assertion mid-operation SHALL discard pending responses immediately; the first grant is possible on the first edge after reset deasserts.

Configuration
REQ-029 With ALU_ARB_FIXED_PRIO_EN defined, ties SHALL always be granted to requester 0 and last_grant is unused; without the macro, the round-robin of REQ-018 applies.

Verification
REQ-030 Req0 ADD 123,234 alone -> req_ready0=1 that cycle; next cycle rsp_valid0=1, result0=357, zero0=0, ops_done=1.
REQ-031 Req1 SUB 123,123 -> result1=0, zero1=1; req0 idle, so req_ready0 stays 0.
REQ-032 Both requesters valid for 4 cycles with rsp_ready=1 (round-robin build) -> grant order 0,1,0,1; with ALU_ARB_FIXED_PRIO_EN -> 0,0,0,0.
REQ-033 Req0 OR 0,0xFFFF with saveHigh0=1 -> alu_saveHigh=1 during the grant; result0 equals alu_result captured that edge.
REQ-034 Backpressure: rsp_valid0=1, rsp_ready0=0, req_valid0=1 -> no grant to 0, result0 is stable, and req1 may still be granted; raising rsp_ready0 -> grant to 0 that same cycle.
REQ-035 Reset pulled low with both responses pending -> rsp_valid0/1 drop to 0 without waiting for clk; ops_done=0; after release, a tie grants requester 0.
